// File: rtl/lsu_req_ctrl_pkg.sv
// Shared LSU constants: datapath width, RV32 load/store funct3 codes and
// the request legality check used when an instruction is accepted from EXU.
package lsu_req_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Misaligned, illegal width code, or both classes at once; bypass never errs.
    function automatic logic f_req_err(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic illegal;
        logic misal;
        illegal = ld ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 >= 3'd3);
        misal   = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a != 2'd0);
        return (ld & st) | ((ld | st) & (illegal | misal));
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Load lane select and sign/zero extension of a responder word.
module lsu_ld_ext
    import lsu_req_ctrl_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_addr_lo,
    input  logic [2:0]           i_funct3,
    output logic [CPU_WIDTH-1:0] o_ldata
);

    logic [CPU_WIDTH-1:0] w_shift;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_ldata = '0;
        case (i_funct3)
            F3_B:    o_ldata = {{(CPU_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_ldata = {{(CPU_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            F3_W:    o_ldata = w_shift;
            F3_BU:   o_ldata = {{(CPU_WIDTH-8){1'b0}}, w_shift[7:0]};
            F3_HU:   o_ldata = {{(CPU_WIDTH-16){1'b0}}, w_shift[15:0]};
            default: o_ldata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// LSU initiator: one EXU memory instruction -> one word-aligned SRAM access,
// then an aligned/extended result (or error/bypass completion) to WBU.
module lsu_req_ctrl
    import lsu_req_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pre_valid,
    output logic                   o_pre_ready,
    input  logic                   i_load,
    input  logic                   i_store,
    input  logic [2:0]             i_funct3,
    input  logic [CPU_WIDTH-1:0]   i_addr,
    input  logic [CPU_WIDTH-1:0]   i_wdata,
    output logic                   o_ren,
    output logic                   o_wen,
    output logic [CPU_WIDTH-1:0]   o_raddr,
    output logic [CPU_WIDTH-1:0]   o_waddr,
    output logic [CPU_WIDTH/8-1:0] o_wmask,
    output logic [CPU_WIDTH-1:0]   o_wdata,
    input  logic [CPU_WIDTH-1:0]   i_rdata,
    input  logic                   i_mem_valid,
    output logic                   o_post_valid,
    input  logic                   i_post_ready,
    output logic [CPU_WIDTH-1:0]   o_ldata,
    output logic                   o_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam int unsigned   CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [CPU_WIDTH-1:0]     r_addr;
    logic [2:0]               r_funct3;
    logic                     r_load;
    logic                     r_store;
    logic [CPU_WIDTH/8-1:0]   r_wmask;
    logic [CPU_WIDTH-1:0]     r_wdata;
    logic [CPU_WIDTH-1:0]     r_ldata;
    logic                     r_err;
    logic [CW-1:0]            r_cnt;

    logic                     w_req_err;
    logic [4:0]               w_sh;
    logic [CPU_WIDTH/8-1:0]   w_wmask;
    logic [CPU_WIDTH-1:0]     w_wdata;
    logic [CPU_WIDTH-1:0]     w_ldext;

    assign w_req_err = f_req_err(i_load, i_store, i_funct3, i_addr[1:0]);
    assign w_sh      = {i_addr[1:0], 3'b000};

    always_comb begin
        w_wmask = '0;
        w_wdata = '0;
        case (i_funct3[1:0])
            2'd0: begin
                w_wmask = 4'b0001 << i_addr[1:0];
                w_wdata = CPU_WIDTH'(i_wdata[7:0]) << w_sh;
            end
            2'd1: begin
                w_wmask = 4'b0011 << i_addr[1:0];
                w_wdata = CPU_WIDTH'(i_wdata[15:0]) << w_sh;
            end
            default: begin
                w_wmask = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    lsu_ld_ext u_ld_ext (
        .i_rdata   (i_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_ldata   (w_ldext)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_pre_valid) w_next = (w_req_err || !(i_load || i_store)) ? S_DONE : S_REQ;
            S_REQ:  w_next = S_WAIT;
            S_WAIT: if (i_mem_valid || r_cnt == CNT_LAST) w_next = S_DONE;
            S_DONE: if (i_post_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_pre_ready  = (r_state == S_IDLE);
        o_ren        = (r_state == S_REQ) & r_load;
        o_wen        = (r_state == S_REQ) & r_store;
        o_post_valid = (r_state == S_DONE);
    end

    // Result registers only move on accept and in WAIT, so DONE holds them stable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_funct3 <= '0;
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_wmask  <= '0;
            r_wdata  <= '0;
            r_ldata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_pre_valid) begin
                    r_addr   <= i_addr;
                    r_funct3 <= i_funct3;
                    r_load   <= i_load;
                    r_store  <= i_store;
                    r_err    <= w_req_err;
                    r_ldata  <= '0;
                    r_wmask  <= (i_store && !w_req_err) ? w_wmask : '0;
                    r_wdata  <= (i_store && !w_req_err) ? w_wdata : '0;
                end
                S_REQ: r_cnt <= '0;
                S_WAIT: begin
                    if (i_mem_valid)            r_ldata <= r_load ? w_ldext : '0;
                    else if (r_cnt == CNT_LAST) r_err   <= 1'b1;
                    else                        r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_raddr = {r_addr[CPU_WIDTH-1:2], 2'b00};
    assign o_waddr = {r_addr[CPU_WIDTH-1:2], 2'b00};
    assign o_wmask = r_wmask;
    assign o_wdata = r_wdata;
    assign o_ldata = r_ldata;
    assign o_err   = r_err;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed self-checking bench for lsu_req_ctrl (TIMEOUT overridden to 4).
module tb_lsu_req_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ren;
    logic        o_wen;
    logic [31:0] o_raddr;
    logic [31:0] o_waddr;
    logic [3:0]  o_wmask;
    logic [31:0] o_wdata;
    logic [31:0] i_rdata;
    logic        i_mem_valid;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [31:0] o_ldata;
    logic        o_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    lsu_req_ctrl #(.TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ren        (o_ren),
        .o_wen        (o_wen),
        .o_raddr      (o_raddr),
        .o_waddr      (o_waddr),
        .o_wmask      (o_wmask),
        .o_wdata      (o_wdata),
        .i_rdata      (i_rdata),
        .i_mem_valid  (i_mem_valid),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_ldata      (o_ldata),
        .o_err        (o_err)
    );

    task step;
        @(posedge i_clk);
        #1;
    endtask

    // Handshake in the current cycle; returns one cycle later (T+1).
    task start_req(input logic ld, input logic st, input logic [2:0] f3,
                   input logic [31:0] addr, input logic [31:0] wdata);
        i_load = ld; i_store = st; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        i_pre_valid = 1'b1;
        step();
        i_pre_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    endtask

    task release_done;
        i_post_ready = 1'b1;
        step();
        i_post_ready = 1'b0;
    endtask

    task test_reset;
        i_rst_n = 1'b0;
        step(); step();
        i_rst_n = 1'b1;
        n_checks++; if (o_pre_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ready got %b exp 1", o_pre_ready); end
        n_checks++; if ({o_ren, o_wen, o_post_valid, o_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes got %b exp 0000", {o_ren, o_wen, o_post_valid, o_err}); end
        n_checks++; if ({o_raddr, o_waddr} !== 64'd0) begin n_fail++; $display("FAIL rst_addr got %h %h exp 0", o_raddr, o_waddr); end
        n_checks++; if ({o_wmask, o_wdata, o_ldata} !== 68'd0) begin n_fail++; $display("FAIL rst_data got %h %h %h exp 0", o_wmask, o_wdata, o_ldata); end
    endtask

    task test_lw;
        start_req(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0);
        n_checks++; if ({o_ren, o_wen} !== 2'b10) begin n_fail++; $display("FAIL lw_strobe got %b exp 10", {o_ren, o_wen}); end
        n_checks++; if (o_raddr !== 32'h8000_0010) begin n_fail++; $display("FAIL lw_raddr got %h exp 80000010", o_raddr); end
        n_checks++; if (o_pre_ready !== 1'b0) begin n_fail++; $display("FAIL lw_pre_ready got %b exp 0", o_pre_ready); end
        step();
        n_checks++; if ({o_ren, o_post_valid} !== 2'b00) begin n_fail++; $display("FAIL lw_wait got %b exp 00", {o_ren, o_post_valid}); end
        i_rdata = 32'hDEAD_BEEF; i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        n_checks++; if (o_post_valid !== 1'b1) begin n_fail++; $display("FAIL lw_post_valid got %b exp 1", o_post_valid); end
        n_checks++; if (o_ldata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_ldata got %h exp deadbeef", o_ldata); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b exp 0", o_err); end
        release_done();
        n_checks++; if ({o_pre_ready, o_post_valid} !== 2'b10) begin n_fail++; $display("FAIL lw_back_idle got %b exp 10", {o_pre_ready, o_post_valid}); end
    endtask

    logic [2:0]  ext_f3   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ext_addr [4] = '{32'h2000_0003, 32'h2000_0003, 32'h2000_0002, 32'h2000_0002};
    logic [31:0] ext_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};

    task test_load_ext;
        for (int i = 0; i < 4; i++) begin
            start_req(1'b1, 1'b0, ext_f3[i], ext_addr[i], 32'h0);
            step();
            i_rdata = 32'h80FF_0000; i_mem_valid = 1'b1;
            step();
            i_mem_valid = 1'b0;
            n_checks++; if ({o_post_valid, o_err, o_ldata} !== {2'b10, ext_exp[i]}) begin
                n_fail++; $display("FAIL ldext_%0d got pv=%b err=%b ldata=%h exp pv=1 err=0 ldata=%h", i, o_post_valid, o_err, o_ldata, ext_exp[i]);
            end
            release_done();
        end
    endtask

    task test_store;
        start_req(1'b0, 1'b1, 3'd1, 32'h1000_0002, 32'h1234_ABCD);
        n_checks++; if ({o_ren, o_wen} !== 2'b01) begin n_fail++; $display("FAIL sh_strobe got %b exp 01", {o_ren, o_wen}); end
        n_checks++; if (o_wmask !== 4'b1100) begin n_fail++; $display("FAIL sh_wmask got %b exp 1100", o_wmask); end
        n_checks++; if (o_wdata !== 32'hABCD_0000) begin n_fail++; $display("FAIL sh_wdata got %h exp abcd0000", o_wdata); end
        n_checks++; if (o_waddr !== 32'h1000_0000) begin n_fail++; $display("FAIL sh_waddr got %h exp 10000000", o_waddr); end
        step();
        n_checks++; if (o_wen !== 1'b0) begin n_fail++; $display("FAIL sh_wen_pulse got %b exp 0", o_wen); end
        i_rdata = 32'hFFFF_FFFF; i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        n_checks++; if ({o_post_valid, o_err, o_ldata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL sh_done got pv=%b err=%b ldata=%h exp 1 0 0", o_post_valid, o_err, o_ldata); end
        release_done();
        start_req(1'b0, 1'b1, 3'd0, 32'h1000_0005, 32'hFFFF_FF5A);
        n_checks++; if ({o_wen, o_wmask, o_wdata} !== {1'b1, 4'b0010, 32'h0000_5A00}) begin n_fail++; $display("FAIL sb_lanes got wen=%b mask=%b data=%h exp 1 0010 00005a00", o_wen, o_wmask, o_wdata); end
        step();
        i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        release_done();
    endtask

    logic        er_ld   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        er_st   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  er_f3   [6] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd2, 3'd2};
    logic [31:0] er_addr [6] = '{32'h0000_0101, 32'h0000_0103, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0102};

    task test_error;
        for (int i = 0; i < 6; i++) begin
            start_req(er_ld[i], er_st[i], er_f3[i], er_addr[i], 32'h5555_5555);
            n_checks++; if ({o_post_valid, o_err, o_ren, o_wen, o_ldata} !== {4'b1100, 32'h0}) begin
                n_fail++; $display("FAIL err_%0d got pv=%b err=%b ren=%b wen=%b ldata=%h exp 1 1 0 0 0", i, o_post_valid, o_err, o_ren, o_wen, o_ldata);
            end
            release_done();
        end
        start_req(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
        n_checks++; if ({o_post_valid, o_err, o_ren, o_wen, o_ldata} !== {4'b1000, 32'h0}) begin
            n_fail++; $display("FAIL bypass got pv=%b err=%b ren=%b wen=%b ldata=%h exp 1 0 0 0 0", o_post_valid, o_err, o_ren, o_wen, o_ldata);
        end
        release_done();
    endtask

    task test_timeout;
        start_req(1'b1, 1'b0, 3'd2, 32'h3000_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait_%0d got pv=%b exp 0", i, o_post_valid); end
        end
        step();
        n_checks++; if ({o_post_valid, o_err, o_ldata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL to_done got pv=%b err=%b ldata=%h exp 1 1 0", o_post_valid, o_err, o_ldata); end
        release_done();
        i_rdata = 32'hCAFE_F00D; i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        n_checks++; if ({o_pre_ready, o_post_valid, o_ren} !== 3'b100) begin n_fail++; $display("FAIL to_late_valid got %b exp 100", {o_pre_ready, o_post_valid, o_ren}); end
        start_req(1'b1, 1'b0, 3'd2, 32'h3000_0004, 32'h0);
        step();
        i_rdata = 32'h1122_3344; i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        n_checks++; if ({o_post_valid, o_err, o_ldata} !== {2'b10, 32'h1122_3344}) begin n_fail++; $display("FAIL to_recover got pv=%b err=%b ldata=%h exp 1 0 11223344", o_post_valid, o_err, o_ldata); end
        release_done();
        // Response on the last allowed WAIT cycle beats the timeout.
        start_req(1'b1, 1'b0, 3'd2, 32'h3000_0008, 32'h0);
        step(); step(); step(); step();
        i_rdata = 32'h55AA_55AA; i_mem_valid = 1'b1;
        step();
        i_mem_valid = 1'b0;
        n_checks++; if ({o_post_valid, o_err, o_ldata} !== {2'b10, 32'h55AA_55AA}) begin n_fail++; $display("FAIL to_race got pv=%b err=%b ldata=%h exp 1 0 55aa55aa", o_post_valid, o_err, o_ldata); end
        release_done();
    endtask

    task test_stall_reset;
        start_req(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
        step();
        i_rdata = 32'h0BAD_F00D; i_mem_valid = 1'b1;
        step();
        i_rdata = 32'h0; i_pre_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'd2;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({o_post_valid, o_pre_ready, o_ren, o_err, o_ldata} !== {4'b1000, 32'h0BAD_F00D}) begin
                n_fail++; $display("FAIL stall_%0d got pv=%b prdy=%b ren=%b err=%b ldata=%h exp 1 0 0 0 0badf00d", i, o_post_valid, o_pre_ready, o_ren, o_err, o_ldata);
            end
            step();
        end
        i_pre_valid = 1'b0; i_load = 1'b0; i_mem_valid = 1'b0;
        release_done();
        start_req(1'b1, 1'b0, 3'd2, 32'h0000_0044, 32'h0);
        step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        n_checks++; if (o_pre_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ready got %b exp 1", o_pre_ready); end
        n_checks++; if ({o_ren, o_wen, o_post_valid, o_err, o_raddr, o_waddr, o_wmask, o_wdata, o_ldata} !== 136'd0) begin
            n_fail++; $display("FAIL midrst_outputs got ren=%b wen=%b pv=%b err=%b raddr=%h ldata=%h exp all 0", o_ren, o_wen, o_post_valid, o_err, o_raddr, o_ldata);
        end
        step();
        n_checks++; if ({o_pre_ready, o_post_valid, o_ren} !== 3'b100) begin n_fail++; $display("FAIL midrst_stays_idle got %b exp 100", {o_pre_ready, o_post_valid, o_ren}); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_pre_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_funct3 = 3'd0; i_addr = '0; i_wdata = '0; i_rdata = '0;
        i_mem_valid = 1'b0; i_post_ready = 1'b0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_error();
        test_timeout();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
